// File: rtl/cordic_report_pkg.sv
// Shared constants, mode encodings, frame FSM states and frame byte helpers for the CORDIC UART reporter.
// Pure definitions; no latency or flow control lives here.
package cordic_report_pkg;

    localparam logic [7:0] SYNC0     = 8'hAA;
    localparam logic [7:0] SYNC1     = 8'h55;
    localparam int         FRAME_LEN = 12;

    localparam logic [1:0] MODE_OFF      = 2'd0;
    localparam logic [1:0] MODE_SINCOS   = 2'd1;
    localparam logic [1:0] MODE_SINHCOSH = 2'd2;
    localparam logic [1:0] MODE_EXP      = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SEND,
        ST_DONE
    } frame_state_t;

    // XOR of the mode byte and all eight result bytes, computed once at capture time.
    function automatic logic [7:0] frame_chk(input logic [1:0]  mode,
                                             input logic [31:0] r1,
                                             input logic [31:0] r2);
        return {6'b0, mode}
             ^ r1[31:24] ^ r1[23:16] ^ r1[15:8] ^ r1[7:0]
             ^ r2[31:24] ^ r2[23:16] ^ r2[15:8] ^ r2[7:0];
    endfunction

    function automatic logic [7:0] frame_byte(input logic [3:0]  idx,
                                              input logic [1:0]  mode,
                                              input logic [31:0] r1,
                                              input logic [31:0] r2,
                                              input logic [7:0]  chk);
        logic [7:0] b;
        case (idx)
            4'd0:    b = SYNC0;
            4'd1:    b = SYNC1;
            4'd2:    b = {6'b0, mode};
            4'd3:    b = r1[31:24];
            4'd4:    b = r1[23:16];
            4'd5:    b = r1[15:8];
            4'd6:    b = r1[7:0];
            4'd7:    b = r2[31:24];
            4'd8:    b = r2[23:16];
            4'd9:    b = r2[15:8];
            4'd10:   b = r2[7:0];
            default: b = chk;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serialiser: start latched on the edge it is seen, start bit driven the next cycle, BAUD_DIV cycles per bit.
// A start presented during the last stop-bit cycle chains the next byte with no idle gap; start is ignored otherwise while busy.
module uart_tx_byte #(
    parameter int BAUD_DIV = 868
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       byte_done,
    output logic       busy
);

    localparam int CW = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 2;
    localparam logic [CW-1:0] RELOAD = CW'(BAUD_DIV - 1);

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    tx_state_t     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic          bit_end;

    assign bit_end   = (cnt_q == '0);
    assign byte_done = (state_q == TX_STOP) && bit_end;
    assign busy      = (state_q != TX_IDLE);
    assign tx        = tx_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        case (state_q)
            TX_IDLE: begin
                tx_d = 1'b1;
                if (start) begin
                    state_d = TX_START;
                    cnt_d   = RELOAD;
                    shift_d = data;
                    tx_d    = 1'b0;
                end
            end
            TX_START: begin
                if (bit_end) begin
                    state_d = TX_DATA;
                    cnt_d   = RELOAD;
                    bit_d   = 3'd0;
                    tx_d    = shift_q[0];
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            TX_DATA: begin
                if (bit_end) begin
                    cnt_d = RELOAD;
                    if (bit_q == 3'd7) begin
                        state_d = TX_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = shift_q >> 1;
                        tx_d    = shift_q[1];
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            TX_STOP: begin
                if (bit_end) begin
                    // Chaining here keeps the stop bit exactly BAUD_DIV cycles.
                    if (start) begin
                        state_d = TX_START;
                        cnt_d   = RELOAD;
                        shift_d = data;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = TX_IDLE;
                        tx_d    = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = TX_IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= TX_IDLE;
            cnt_q   <= '0;
            bit_q   <= 3'd0;
            shift_q <= 8'h00;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

endmodule

// File: rtl/cordic_uart_reporter.sv
// Frames each accepted CORDIC result as a 12-byte 8N1 UART packet; start bit appears two edges after the capture strobe.
// No backpressure: results arriving while a frame is in flight are dropped and counted (saturating).
module cordic_uart_reporter
    import cordic_report_pkg::*;
#(
    parameter int CLK_HZ   = 100_000_000,
    parameter int BAUD     = 115200,
    parameter int BAUD_DIV = CLK_HZ / BAUD
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic [1:0]  cordic_mode,
    input  logic [31:0] cordic_result_1,
    input  logic [31:0] cordic_result_2,
    input  logic        cordic_result_valid,
    output logic        uart_tx,
    output logic        tx_busy,
    output logic [15:0] frame_cnt,
    output logic [7:0]  drop_cnt
);

    frame_state_t state_q, state_d;
    logic [3:0]   idx_q, idx_d;
    logic [1:0]   mode_q, mode_d;
    logic [31:0]  r1_q, r1_d;
    logic [31:0]  r2_q, r2_d;
    logic [7:0]   chk_q, chk_d;
    logic [15:0]  frame_cnt_q, frame_cnt_d;
    logic [7:0]   drop_cnt_q, drop_cnt_d;

    logic         capture;
    logic         byte_start;
    logic [3:0]   byte_idx;
    logic [7:0]   byte_dat;
    logic         byte_done;
    logic         byte_busy;

    assign capture  = cordic_result_valid && (cordic_mode != MODE_OFF);
    assign byte_dat = frame_byte(byte_idx, mode_q, r1_q, r2_q, chk_q);

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        mode_d      = mode_q;
        r1_d        = r1_q;
        r2_d        = r2_q;
        chk_d       = chk_q;
        frame_cnt_d = frame_cnt_q;
        drop_cnt_d  = drop_cnt_q;
        byte_start  = 1'b0;
        byte_idx    = idx_q;

        // Any accepted-mode strobe outside IDLE is lost, including one landing on DONE.
        if (capture && (state_q != ST_IDLE) && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end

        case (state_q)
            ST_IDLE: begin
                if (capture) begin
                    mode_d  = cordic_mode;
                    r1_d    = cordic_result_1;
                    r2_d    = cordic_result_2;
                    chk_d   = frame_chk(cordic_mode, cordic_result_1, cordic_result_2);
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                idx_d      = 4'd0;
                byte_idx   = 4'd0;
                byte_start = 1'b1;
                state_d    = ST_SEND;
            end
            ST_SEND: begin
                if (byte_done) begin
                    if (idx_q < 4'(FRAME_LEN - 1)) begin
                        idx_d      = idx_q + 4'd1;
                        byte_idx   = idx_q + 4'd1;
                        byte_start = 1'b1;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                frame_cnt_d = frame_cnt_q + 16'd1;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= ST_IDLE;
            idx_q       <= 4'd0;
            mode_q      <= MODE_OFF;
            r1_q        <= 32'h0;
            r2_q        <= 32'h0;
            chk_q       <= 8'h00;
            frame_cnt_q <= 16'h0;
            drop_cnt_q  <= 8'h00;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            mode_q      <= mode_d;
            r1_q        <= r1_d;
            r2_q        <= r2_d;
            chk_q       <= chk_d;
            frame_cnt_q <= frame_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    uart_tx_byte #(
        .BAUD_DIV (BAUD_DIV)
    ) u_tx_byte (
        .clk       (sys_clk),
        .rst_n     (sys_rst_n),
        .start     (byte_start),
        .data      (byte_dat),
        .tx        (uart_tx),
        .byte_done (byte_done),
        .busy      (byte_busy)
    );

    // The serialiser stays busy across chained bytes, so LOAD is the only gap to cover.
    assign tx_busy   = (state_q == ST_LOAD) || byte_busy;
    assign frame_cnt = frame_cnt_q;
    assign drop_cnt  = drop_cnt_q;

endmodule
